// File: rtl/xgs_powerup_seq.sv
// -----------------------------------------------------------------------------
// xgs_powerup_seq
//
// Power-up / power-down sequencer for the XGS image sensor. Turns the level
// request from the SENSOR_POWERUP register into a timed sequence: enable the
// sensor external clock, release sensor reset, wait for sensor ready, and
// report progress in SENSOR_STATUS. Dropping the request at any point runs
// the reverse sequence: reset is asserted first, and the clock stops only
// after T_RST2CLK cycles.
//
// Parameters (cycles, 1..65535, 0 behaves as 1):
//   T_CLK2RST  clock enable  -> reset release
//   T_RST2RDY  reset release -> ready
//   T_RST2CLK  reset assert  -> clock disable (power-down)
//
// Ports:
//   axiClk100MHz      in   system clock, rising edge
//   axiReset          in   synchronous, active-high reset
//   cfg_powerup       in   1 = power up, 0 = power down (level)
//   sensor_extclk_en  out  sensor external clock buffer enable
//   sensor_reset_n    out  sensor reset, active-low
//   stat_clk_en       out  copy of sensor_extclk_en  (SENSOR_STATUS[0])
//   stat_reset_n      out  copy of sensor_reset_n    (SENSOR_STATUS[1])
//   stat_ready        out  sensor usable, SPI allowed (SENSOR_STATUS[2])
//   stat_busy         out  sequence in progress (CLK_ON, RST_WAIT, PDN_RST)
//   stat_state        out  OFF=0 CLK_ON=1 RST_WAIT=2 READY=3 PDN_RST=4
//   evt_ready         out  one-cycle pulse on entry to READY
//   evt_off           out  one-cycle pulse on entry to OFF from PDN_RST
// -----------------------------------------------------------------------------
module xgs_powerup_seq #(
    parameter int unsigned T_CLK2RST = 100,
    parameter int unsigned T_RST2RDY = 200,
    parameter int unsigned T_RST2CLK = 50
) (
    input  logic       axiClk100MHz,
    input  logic       axiReset,
    input  logic       cfg_powerup,
    output logic       sensor_extclk_en,
    output logic       sensor_reset_n,
    output logic       stat_clk_en,
    output logic       stat_reset_n,
    output logic       stat_ready,
    output logic       stat_busy,
    output logic [2:0] stat_state,
    output logic       evt_ready,
    output logic       evt_off
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CLK_ON   = 3'd1,
        ST_RST_WAIT = 3'd2,
        ST_READY    = 3'd3,
        ST_PDN_RST  = 3'd4
    } state_t;

    // Counter load values: a state lasts (load + 1) cycles, and a zero
    // parameter is clamped so the state still lasts one cycle.
    localparam logic [15:0] LOAD_CLK2RST = (T_CLK2RST == 0) ? 16'd0 : 16'(T_CLK2RST - 1);
    localparam logic [15:0] LOAD_RST2RDY = (T_RST2RDY == 0) ? 16'd0 : 16'(T_RST2RDY - 1);
    localparam logic [15:0] LOAD_RST2CLK = (T_RST2CLK == 0) ? 16'd0 : 16'(T_RST2CLK - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_next;

    // Next-state and shared counter. The counter is loaded on entry to a
    // timed state and the state is left on the cycle after it reads zero.
    // A dropped request aborts CLK_ON / RST_WAIT ahead of counter expiry.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals; a missing
        // branch would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_OFF: begin
                cnt_next = '0;
                if (cfg_powerup) begin
                    state_next = ST_CLK_ON;
                    cnt_next   = LOAD_CLK2RST;
                end
            end
            ST_CLK_ON: begin
                if (!cfg_powerup) begin
                    state_next = ST_PDN_RST;
                    cnt_next   = LOAD_RST2CLK;
                end else if (cnt == 16'd0) begin
                    state_next = ST_RST_WAIT;
                    cnt_next   = LOAD_RST2RDY;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            ST_RST_WAIT: begin
                if (!cfg_powerup) begin
                    state_next = ST_PDN_RST;
                    cnt_next   = LOAD_RST2CLK;
                end else if (cnt == 16'd0) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            ST_READY: begin
                cnt_next = '0;
                if (!cfg_powerup) begin
                    state_next = ST_PDN_RST;
                    cnt_next   = LOAD_RST2CLK;
                end
            end
            // The request is ignored here so reset always precedes clock stop
            // by the full T_RST2CLK; arriving in OFF forces one OFF cycle.
            ST_PDN_RST: begin
                if (cnt == 16'd0) begin
                    state_next = ST_OFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge as the state register.
    always_ff @(posedge axiClk100MHz) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples pre-edge values regardless of statement order.
        if (axiReset) begin
            state            <= ST_OFF;
            cnt              <= '0;
            sensor_extclk_en <= 1'b0;
            sensor_reset_n   <= 1'b0;
            stat_ready       <= 1'b0;
            stat_busy        <= 1'b0;
            evt_ready        <= 1'b0;
            evt_off          <= 1'b0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            sensor_extclk_en <= (state_next != ST_OFF);
            sensor_reset_n   <= (state_next == ST_RST_WAIT) || (state_next == ST_READY);
            stat_ready       <= (state_next == ST_READY);
            stat_busy        <= (state_next == ST_CLK_ON) || (state_next == ST_RST_WAIT) ||
                                (state_next == ST_PDN_RST);
            evt_ready        <= (state_next == ST_READY) && (state != ST_READY);
            evt_off          <= (state_next == ST_OFF) && (state == ST_PDN_RST);
        end
    end

    // Status copies come straight from registers, so they stay registered.
    assign stat_clk_en  = sensor_extclk_en;
    assign stat_reset_n = sensor_reset_n;
    assign stat_state   = state;

endmodule
